pipe_stage_multilane: RTL and testbench

- Parametrised successor to the fixed-width stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- One instance forms one pipeline boundary for an N-lane (default 2, dual-issue) machine.
- Adds a valid/ready handshake with a 2-entry skid buffer, so downstream stall does not combinationally reach upstream.
- Adds per-lane valid bits, per-lane kill on entry, whole-stage flush, optional dropping of all-invalid beats, and a saturating stall counter for performance analysis.

---
 rtl/pipe_stage_multilane.sv | 101 ++++++++++
 tb/tb_pipe_stage_multilane.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_multilane.sv
// One pipeline boundary for an N-lane machine: head register H drives the outputs,
// skid register S absorbs one beat of downstream stall so out_ready never reaches in_ready.
module pipe_stage_multilane #(
    parameter int unsigned WIDTH        = 48,
    parameter int unsigned LANES        = 2,
    parameter bit          DROP_EMPTY   = 1'b1,
    parameter bit          ZERO_INVALID = 1'b1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       in_lane_valid,
    input  logic [LANES-1:0]       in_kill,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       out_lane_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [1:0]             occupancy,
    output logic [CNT_W-1:0]       stall_cnt
);
    // Handshake: a beat moves on an edge where valid and ready are both high;
    // valid never waits on ready, and in_ready is a pure function of registered state.

    logic                   h_valid, s_valid;
    logic [LANES-1:0]       h_lv, s_lv;
    logic [LANES*WIDTH-1:0] h_data, s_data;

    logic                   accept, pop, keep;
    logic [LANES-1:0]       new_lv;
    logic [LANES*WIDTH-1:0] new_data;

    always_comb begin
        new_lv = in_lane_valid & ~in_kill;
        new_data = in_data;
        for (int i = 0; i < LANES; i++) begin
            if (ZERO_INVALID && !new_lv[i]) begin
                new_data[i*WIDTH +: WIDTH] = '0;
            end
        end
        accept = in_valid & in_ready;
        pop    = out_valid & out_ready;
        // An all-killed beat is still consumed upstream, it just never gets a slot.
        keep   = accept & (!DROP_EMPTY || (new_lv != '0));
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            h_valid <= 1'b0;
            h_lv    <= '0;
            h_data  <= '0;
            s_valid <= 1'b0;
            s_lv    <= '0;
            s_data  <= '0;
        end else if (!h_valid) begin
            if (keep) begin
                h_valid <= 1'b1;
                h_lv    <= new_lv;
                h_data  <= new_data;
            end
        end else if (pop) begin
            if (s_valid) begin
                h_lv    <= s_lv;
                h_data  <= s_data;
                s_valid <= 1'b0;
                s_lv    <= '0;
                s_data  <= '0;
            end else if (keep) begin
                h_lv    <= new_lv;
                h_data  <= new_data;
            end else begin
                h_valid <= 1'b0;
                h_lv    <= '0;
                h_data  <= '0;
            end
        end else if (keep) begin
            s_valid <= 1'b1;
            s_lv    <= new_lv;
            s_data  <= new_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // S can only be full while H is full, so S alone decides readiness.
    assign in_ready       = ~s_valid;
    assign out_valid      = h_valid;
    assign out_lane_valid = h_lv;
    assign out_data       = h_data;
    assign occupancy      = {h_valid & s_valid, h_valid ^ s_valid};

endmodule

// File: tb/tb_pipe_stage_multilane.sv
// Bench for pipe_stage_multilane: queue-based reference model checked every cycle,
// a vector table for kill/drop, and hand sequences for the multi-cycle corners.
module tb_pipe_stage_multilane;
    localparam int W     = 48;
    localparam int L     = 2;
    localparam int CW    = 4;
    localparam int DW    = L * W;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [L-1:0]  in_lane_valid, in_kill, out_lane_valid;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    pipe_stage_multilane #(.WIDTH(W), .LANES(L), .DROP_EMPTY(1'b1), .ZERO_INVALID(1'b1), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_valid(in_lane_valid), .in_kill(in_kill), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_valid(out_lane_valid), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: stored beats in acceptance order, plus a stall tally.
    logic [DW-1:0] exp_q[$];
    logic [L-1:0]  exp_lv_q[$];
    int            exp_cnt = 0;

    function automatic logic [DW-1:0] pack2(input logic [W-1:0] l1, input logic [W-1:0] l0);
        return {l1, l0};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        check("model out_valid", DW'(out_valid), DW'(exp_q.size() > 0));
        check("model in_ready", DW'(in_ready), DW'(exp_q.size() < 2));
        check("model occupancy", DW'(occupancy), DW'(exp_q.size()));
        check("model stall_cnt", DW'(stall_cnt), DW'(exp_cnt));
        if (exp_q.size() > 0) begin
            check("model lane_valid", DW'(out_lane_valid), DW'(exp_lv_q[0]));
            check("model data", out_data, exp_q[0]);
        end
    endtask

    // One clock: decide what the model does with the current inputs, take the edge, compare.
    task automatic tick();
        logic          acc, pp, stall;
        logic [L-1:0]  m;
        logic [DW-1:0] d;
        acc   = in_valid && (exp_q.size() < 2);
        pp    = out_ready && (exp_q.size() > 0);
        stall = !out_ready && (exp_q.size() > 0);
        m     = in_lane_valid & ~in_kill;
        d     = in_data;
        for (int i = 0; i < L; i++) if (!m[i]) d[i*W +: W] = '0;
        @(posedge clk);
        #1;
        if (reset) begin
            exp_q.delete();
            exp_lv_q.delete();
            exp_cnt = 0;
        end else begin
            if (stall && exp_cnt < CMAX) exp_cnt++;
            if (pp) begin
                void'(exp_q.pop_front());
                void'(exp_lv_q.pop_front());
            end
            if (flush) begin
                exp_q.delete();
                exp_lv_q.delete();
            end else if (acc && m != '0) begin
                exp_q.push_back(d);
                exp_lv_q.push_back(m);
            end
        end
        check_model();
    endtask

    task automatic drive(input logic v, input logic [L-1:0] lv, input logic [L-1:0] k,
                         input logic [DW-1:0] d, input logic rdy);
        in_valid      = v;
        in_lane_valid = lv;
        in_kill       = k;
        in_data       = d;
        out_ready     = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic          v;
        logic [L-1:0]  lv;
        logic [L-1:0]  k;
        logic [DW-1:0] d;
        logic          rdy;
        logic          e_valid;
        logic [L-1:0]  e_lv;
        logic [DW-1:0] e_data;
        logic [1:0]    e_occ;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 2'b11, 2'b10, pack2(48'h5A, 48'h11), 1'b1, 1'b1, 2'b01, pack2(48'h0, 48'h11), 2'd1};
        vecs[1] = '{1'b1, 2'b11, 2'b11, pack2(48'h66, 48'h77), 1'b1, 1'b0, 2'b00, '0, 2'd0};
        vecs[2] = '{1'b0, 2'b00, 2'b00, '0, 1'b1, 1'b0, 2'b00, '0, 2'd0};
        vecs[3] = '{1'b1, 2'b01, 2'b00, pack2(48'h33, 48'h22), 1'b1, 1'b1, 2'b01, pack2(48'h0, 48'h22), 2'd1};
        vecs[4] = '{1'b1, 2'b10, 2'b00, pack2(48'h55, 48'h44), 1'b1, 1'b1, 2'b10, pack2(48'h55, 48'h0), 2'd1};
        vecs[5] = '{1'b0, 2'b00, 2'b00, '0, 1'b1, 1'b0, 2'b00, '0, 2'd0};
        vecs[6] = '{1'b1, 2'b11, 2'b00, pack2(48'h8, 48'h7), 1'b0, 1'b1, 2'b11, pack2(48'h8, 48'h7), 2'd1};
        vecs[7] = '{1'b1, 2'b11, 2'b11, pack2(48'h9, 48'h9), 1'b0, 1'b1, 2'b11, pack2(48'h8, 48'h7), 2'd1};
        vecs[8] = '{1'b0, 2'b00, 2'b00, '0, 1'b1, 1'b0, 2'b00, '0, 2'd0};

        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);

        // Reset held two cycles with an all-ones beat offered.
        reset = 1'b1;
        drive(1'b1, 2'b11, 2'b00, {DW{1'b1}}, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);
        check("reset out_valid", DW'(out_valid), '0);
        check("reset out_data", out_data, '0);
        check("reset lane_valid", DW'(out_lane_valid), '0);
        check("reset in_ready", DW'(in_ready), DW'(1));
        check("reset occupancy", DW'(occupancy), '0);
        check("reset stall_cnt", DW'(stall_cnt), '0);

        // Streaming: each beat shows up one cycle after it is offered.
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 2'b11, 2'b00, pack2(W'(k + 100), W'(k)), 1'b1);
            tick();
            check("stream data", out_data, pack2(W'(k + 100), W'(k)));
            check("stream in_ready", DW'(in_ready), DW'(1));
        end
        drive(1'b0, '0, '0, '0, 1'b1);
        tick();
        check("stream drained", DW'(out_valid), '0);

        // Backpressure: A, B stored, C held off.
        do_reset();
        drive(1'b1, 2'b11, 2'b00, pack2(48'hA1, 48'hA0), 1'b0);
        tick();
        drive(1'b1, 2'b11, 2'b00, pack2(48'hB1, 48'hB0), 1'b0);
        tick();
        drive(1'b1, 2'b11, 2'b00, pack2(48'hC1, 48'hC0), 1'b0);
        tick();
        check("bp in_ready low", DW'(in_ready), '0);
        tick();
        check("bp occupancy", DW'(occupancy), DW'(2));
        check("bp stall_cnt", DW'(stall_cnt), DW'(3));
        check("bp head A", out_data, pack2(48'hA1, 48'hA0));
        out_ready = 1'b1;
        tick();
        check("bp head B", out_data, pack2(48'hB1, 48'hB0));
        check("bp in_ready back", DW'(in_ready), DW'(1));
        tick();
        check("bp head C", out_data, pack2(48'hC1, 48'hC0));
        drive(1'b0, '0, '0, '0, 1'b1);
        tick();
        check("bp drained", DW'(out_valid), '0);

        // Kill / drop vector table.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].v, vecs[i].lv, vecs[i].k, vecs[i].d, vecs[i].rdy);
            tick();
            check($sformatf("vec%0d out_valid", i), DW'(out_valid), DW'(vecs[i].e_valid));
            check($sformatf("vec%0d occupancy", i), DW'(occupancy), DW'(vecs[i].e_occ));
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d lane_valid", i), DW'(out_lane_valid), DW'(vecs[i].e_lv));
                check($sformatf("vec%0d data", i), out_data, vecs[i].e_data);
            end
        end

        // Flush with a full stage and a beat on offer.
        do_reset();
        drive(1'b1, 2'b11, 2'b00, pack2(48'h1, 48'h1), 1'b0);
        tick();
        drive(1'b1, 2'b11, 2'b00, pack2(48'h2, 48'h2), 1'b0);
        tick();
        check("flush pre occupancy", DW'(occupancy), DW'(2));
        flush = 1'b1;
        drive(1'b1, 2'b11, 2'b00, pack2(48'h3, 48'h3), 1'b0);
        tick();
        flush = 1'b0;
        check("flush out_valid", DW'(out_valid), '0);
        check("flush out_data", out_data, '0);
        check("flush occupancy", DW'(occupancy), '0);
        check("flush in_ready", DW'(in_ready), DW'(1));
        drive(1'b1, 2'b11, 2'b00, pack2(48'hD1, 48'hD0), 1'b1);
        tick();
        check("flush D data", out_data, pack2(48'hD1, 48'hD0));
        check("flush D occ", DW'(occupancy), DW'(1));
        drive(1'b0, '0, '0, '0, 1'b1);
        tick();
        check("flush D alone", DW'(out_valid), '0);

        // Stall counter saturation and clear by reset.
        do_reset();
        drive(1'b1, 2'b01, 2'b00, pack2(48'h0, 48'hE), 1'b0);
        tick();
        drive(1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        check("sat stall_cnt", DW'(stall_cnt), DW'(15));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("sat reset clear", DW'(stall_cnt), '0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), L'($urandom_range(0, 3)), L'($urandom_range(0, 3) & $urandom_range(0, 3)),
                  {16'($urandom), 32'($urandom), 16'($urandom), 32'($urandom)}, 1'($urandom_range(0, 2) != 0));
            flush = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 63) == 0);
            tick();
        end
        reset = 1'b0;
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
